// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the FSM encoding, the NOP word and the PC legality helper.
package fetch_stage_pkg;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
   localparam logic [31:0] WORD_BYTES = 32'd4;

   // Compare the word index rather than the byte address so large depths cannot overflow.
   function automatic logic pc_legal(input logic [31:0] pc, input logic [31:0] words);
      return (pc[1:0] == 2'b00) && ({2'b00, pc[31:2]} < words);
   endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register with bubble > hold > load priority.
// Bubble clears valid and inserts a NOP while keeping the last PC+4.
import fetch_stage_pkg::*;

module ifid_reg (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        load,
   input  logic        bubble,
   input  logic        hold,
   input  logic [31:0] pc4_d,
   input  logic [31:0] instr_d,
   output logic [31:0] pc4,
   output logic [31:0] instr,
   output logic        valid
);

   logic [31:0] pc4_reg;
   logic [31:0] instr_reg;
   logic        valid_reg;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc4_reg   <= 32'h0;
         instr_reg <= NOP_INSTR;
         valid_reg <= 1'b0;
      end else if (bubble) begin
         instr_reg <= NOP_INSTR;
         valid_reg <= 1'b0;
      end else if (!hold && load) begin
         pc4_reg   <= pc4_d;
         instr_reg <= instr_d;
         valid_reg <= 1'b1;
      end
   end

   assign pc4   = pc4_reg;
   assign instr = instr_reg;
   assign valid = valid_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, BOOT/RUN/HALT control and IF/ID register.
// Define FETCH_PERF_CNT_EN to add the fetch and stall performance counters.
import fetch_stage_pkg::*;

module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IMEM_WORDS = 128
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_instr_i,
   output logic [31:0] ifid_pc4_o,
   output logic [31:0] ifid_instr_o,
   output logic        ifid_valid_o,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0] fetch_cnt_o,
   output logic [31:0] stall_cnt_o,
`endif
   output logic        fetch_err_o
);

   localparam logic [31:0] IMEM_WORDS_W = 32'(IMEM_WORDS);

   fetch_state_t state_reg, state_next;
   logic [31:0]  pc_reg, pc_next;
   logic [31:0]  pc_plus4;
   logic         ifid_load;
   logic         ifid_bubble;
   logic         ifid_hold;

   assign pc_plus4 = pc_reg + WORD_BYTES;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg <= ST_BOOT;
         pc_reg    <= RESET_PC;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      pc_next     = pc_reg;
      ifid_load   = 1'b0;
      ifid_bubble = 1'b0;
      ifid_hold   = 1'b0;
      case (state_reg)
         ST_BOOT: begin
            state_next = ST_RUN;
            pc_next    = RESET_PC;
         end
         ST_RUN: begin
            if (redirect_i) begin
               pc_next     = redirect_pc_i;
               ifid_bubble = 1'b1;
            end else if (stall_i) begin
               ifid_hold = 1'b1;
            end else if (!pc_legal(pc_reg, IMEM_WORDS_W)) begin
               // The word at an illegal PC is dropped, never issued.
               state_next  = ST_HALT;
               ifid_bubble = 1'b1;
            end else begin
               pc_next   = pc_plus4;
               ifid_load = 1'b1;
            end
         end
         ST_HALT: begin
            if (redirect_i) begin
               state_next  = ST_RUN;
               pc_next     = redirect_pc_i;
               ifid_bubble = 1'b1;
            end
         end
         default: begin
            state_next = ST_BOOT;
            pc_next    = RESET_PC;
         end
      endcase
   end

   ifid_reg u_ifid_reg (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load    (ifid_load),
      .bubble  (ifid_bubble),
      .hold    (ifid_hold),
      .pc4_d   (pc_plus4),
      .instr_d (imem_instr_i),
      .pc4     (ifid_pc4_o),
      .instr   (ifid_instr_o),
      .valid   (ifid_valid_o)
   );

   assign imem_addr_o = pc_reg;
   assign fetch_err_o = (state_reg == ST_HALT);

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_reg;
   logic [31:0] stall_cnt_reg;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fetch_cnt_reg <= 32'h0;
         stall_cnt_reg <= 32'h0;
      end else begin
         if (ifid_load) fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
         if (ifid_hold) stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
   end

   assign fetch_cnt_o = fetch_cnt_reg;
   assign stall_cnt_o = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, reset/counter
// sequence, then randomized traffic against a behavioural fetch model.
module tb_fetch_stage;

   localparam int          WORDS = 128;
   localparam logic [31:0] RPC   = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        stall_i = 1'b0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = 32'h0;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_instr_i;
   logic [31:0] ifid_pc4_o;
   logic [31:0] ifid_instr_o;
   logic        ifid_valid_o;
   logic        fetch_err_o;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_o;
   logic [31:0] stall_cnt_o;
`endif

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(RPC), .IMEM_WORDS(WORDS)) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .imem_addr_o   (imem_addr_o),
      .imem_instr_i  (imem_instr_i),
      .ifid_pc4_o    (ifid_pc4_o),
      .ifid_instr_o  (ifid_instr_o),
      .ifid_valid_o  (ifid_valid_o),
`ifdef FETCH_PERF_CNT_EN
      .fetch_cnt_o   (fetch_cnt_o),
      .stall_cnt_o   (stall_cnt_o),
`endif
      .fetch_err_o   (fetch_err_o)
   );

   // Memory word i holds i+1; anything outside the array returns a marker.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a[1:0] == 2'b00 && (a / 4) < WORDS) return (a / 4) + 1;
      return 32'hBAD0_0000 | a;
   endfunction

   assign imem_instr_i = mem_word(imem_addr_o);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Behavioural model: booting/halted flags plus the architectural IF/ID contents.
   bit          m_boot, m_halt, m_valid;
   logic [31:0] m_pc, m_pc4, m_instr, m_fcnt, m_scnt;

   task automatic model_step(input bit r, input bit st, input bit rd, input logic [31:0] tgt);
      if (r) begin
         m_boot = 1; m_halt = 0; m_pc = RPC; m_pc4 = 0; m_instr = 0; m_valid = 0;
         m_fcnt = 0; m_scnt = 0;
      end else if (m_boot) begin
         m_boot = 0;
      end else if (rd) begin
         m_pc = tgt; m_valid = 0; m_instr = 0; m_halt = 0;
      end else if (m_halt) begin
         // nothing moves while halted
      end else if (st) begin
         m_scnt++;
      end else if (m_pc % 4 != 0 || m_pc / 4 >= WORDS) begin
         m_halt = 1; m_valid = 0; m_instr = 0;
      end else begin
         m_instr = mem_word(m_pc); m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
         m_fcnt++;
      end
   endtask

   // Drive inputs at the falling edge, let one rising edge pass, return at the next falling edge.
   task automatic cycle(input bit r, input bit st, input bit rd, input logic [31:0] tgt);
      rst_i = r; stall_i = st; redirect_i = rd; redirect_pc_i = tgt;
      @(posedge clk);
      model_step(r, st, rd, tgt);
      @(negedge clk);
      $display("cyc rst=%0b stall=%0b redir=%0b tgt=%h -> addr=%h pc4=%h instr=%h v=%0b err=%0b",
               r, st, rd, tgt, imem_addr_o, ifid_pc4_o, ifid_instr_o, ifid_valid_o, fetch_err_o);
   endtask

   task automatic check_model(input string tag);
      check({tag, ".addr"},  imem_addr_o,  m_pc);
      check({tag, ".pc4"},   ifid_pc4_o,   m_pc4);
      check({tag, ".instr"}, ifid_instr_o, m_instr);
      check({tag, ".valid"}, {31'b0, ifid_valid_o}, {31'b0, m_valid});
      check({tag, ".err"},   {31'b0, fetch_err_o},  {31'b0, m_halt});
`ifdef FETCH_PERF_CNT_EN
      check({tag, ".fcnt"},  fetch_cnt_o, m_fcnt);
      check({tag, ".scnt"},  stall_cnt_o, m_scnt);
`endif
   endtask

   typedef struct {
      bit          stall;
      bit          redir;
      logic [31:0] tgt;
      logic [31:0] addr;
      logic [31:0] pc4;
      logic [31:0] instr;
      bit          valid;
      bit          err;
   } vec_t;

   vec_t vecs[18];

   initial begin
      // Directed table: starts one cycle after reset, DUT in BOOT.
      vecs[0]  = '{0, 0, 32'h0,   32'h0,   32'h0,   32'd0,   0, 0};
      vecs[1]  = '{0, 0, 32'h0,   32'h4,   32'h4,   32'd1,   1, 0};
      vecs[2]  = '{0, 0, 32'h0,   32'h8,   32'h8,   32'd2,   1, 0};
      vecs[3]  = '{1, 0, 32'h0,   32'h8,   32'h8,   32'd2,   1, 0};
      vecs[4]  = '{1, 0, 32'h0,   32'h8,   32'h8,   32'd2,   1, 0};
      vecs[5]  = '{0, 0, 32'h0,   32'hC,   32'hC,   32'd3,   1, 0};
      vecs[6]  = '{1, 1, 32'h40,  32'h40,  32'hC,   32'd0,   0, 0};
      vecs[7]  = '{0, 0, 32'h0,   32'h44,  32'h44,  32'd17,  1, 0};
      vecs[8]  = '{0, 1, 32'h6,   32'h6,   32'h44,  32'd0,   0, 0};
      vecs[9]  = '{0, 0, 32'h0,   32'h6,   32'h44,  32'd0,   0, 1};
      vecs[10] = '{1, 0, 32'h0,   32'h6,   32'h44,  32'd0,   0, 1};
      vecs[11] = '{0, 1, 32'h1F8, 32'h1F8, 32'h44,  32'd0,   0, 0};
      vecs[12] = '{0, 0, 32'h0,   32'h1FC, 32'h1FC, 32'd127, 1, 0};
      vecs[13] = '{0, 0, 32'h0,   32'h200, 32'h200, 32'd128, 1, 0};
      vecs[14] = '{0, 0, 32'h0,   32'h200, 32'h200, 32'd0,   0, 1};
      vecs[15] = '{0, 0, 32'h0,   32'h200, 32'h200, 32'd0,   0, 1};
      vecs[16] = '{0, 1, 32'h0,   32'h0,   32'h200, 32'd0,   0, 0};
      vecs[17] = '{0, 0, 32'h0,   32'h4,   32'h4,   32'd1,   1, 0};

      @(negedge clk);
      cycle(1, 0, 0, 32'h0);
      check("rst.addr",  imem_addr_o,  RPC);
      check("rst.pc4",   ifid_pc4_o,   32'h0);
      check("rst.instr", ifid_instr_o, 32'h0);
      check("rst.valid", {31'b0, ifid_valid_o}, 32'h0);
      check("rst.err",   {31'b0, fetch_err_o},  32'h0);

      for (int i = 0; i < 18; i++) begin
         cycle(0, vecs[i].stall, vecs[i].redir, vecs[i].tgt);
         check($sformatf("vec%0d.addr", i),  imem_addr_o,  vecs[i].addr);
         check($sformatf("vec%0d.pc4", i),   ifid_pc4_o,   vecs[i].pc4);
         check($sformatf("vec%0d.instr", i), ifid_instr_o, vecs[i].instr);
         check($sformatf("vec%0d.valid", i), {31'b0, ifid_valid_o}, {31'b0, vecs[i].valid});
         check($sformatf("vec%0d.err", i),   {31'b0, fetch_err_o},  {31'b0, vecs[i].err});
      end

`ifdef FETCH_PERF_CNT_EN
      // 10 fetches and 3 stalls, then a mid-stream reset.
      cycle(1, 0, 0, 32'h0);
      cycle(0, 0, 0, 32'h0);
      for (int i = 0; i < 7; i++) cycle(0, 0, 0, 32'h0);
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 32'h0);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 32'h0);
      check("perf.fcnt", fetch_cnt_o, 32'd10);
      check("perf.scnt", stall_cnt_o, 32'd3);
      cycle(1, 0, 0, 32'h0);
      check("perf.fcnt_rst", fetch_cnt_o, 32'd0);
      check("perf.scnt_rst", stall_cnt_o, 32'd0);
      check("perf.valid_rst", {31'b0, ifid_valid_o}, 32'h0);
      check("perf.instr_rst", ifid_instr_o, 32'h0);
      check("perf.pc4_rst", ifid_pc4_o, 32'h0);
      check("perf.addr_rst", imem_addr_o, RPC);
`endif

      // Randomized traffic checked against the model.
      cycle(1, 0, 0, 32'h0);
      check_model("rnd_rst");
      for (int i = 0; i < 600; i++) begin
         bit          r, st, rd;
         logic [31:0] tgt;
         int          sel;
         r   = ($urandom_range(0, 63) == 0);
         st  = ($urandom_range(0, 3) == 0);
         rd  = ($urandom_range(0, 9) == 0);
         sel = $urandom_range(0, 9);
         if (sel < 6)       tgt = {23'b0, 7'($urandom_range(0, WORDS - 1)), 2'b00};
         else if (sel == 6) tgt = 32'h1F0 + 4 * $urandom_range(0, 3);
         else if (sel == 7) tgt = {$urandom_range(0, 127), 2'b00} | 32'($urandom_range(1, 3));
         else if (sel == 8) tgt = $urandom;
         else               tgt = 32'h0;
         cycle(r, st, rd, tgt);
         check_model($sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
